// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int unsigned CNT_W_DFLT = 32;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/mem_ready_tracker.sv
// Tracks one memory side: holds a response that arrived while the pipeline was frozen.
module mem_ready_tracker (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic resp,
    input  logic advance,
    output logic ok
);

    logic done_q;

    // A response seen while frozen must be remembered until the pipeline moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (advance) begin
            done_q <= 1'b0;
        end else if (req && resp) begin
            done_q <= 1'b1;
        end
    end

    assign ok = !req || resp || done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline with performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DFLT,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    state_e state_q;
    state_e state_d;
    logic   i_ok;
    logic   d_ok;
    logic   advance;
    logic   lu;
    logic   inc_stall;
    logic   inc_flush;
    logic   inc_lu;

    mem_ready_tracker u_imem_trk (
        .clk     (clk),
        .rst     (rst),
        .req     (imem_req),
        .resp    (imem_resp),
        .advance (advance),
        .ok      (i_ok)
    );

    mem_ready_tracker u_dmem_trk (
        .clk     (clk),
        .rst     (rst),
        .req     (dmem_req),
        .resp    (dmem_resp),
        .advance (advance),
        .ok      (d_ok)
    );

    assign advance = i_ok && d_ok;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks load-use: the dependent instruction is squashed anyway.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        inc_lu     = 1'b0;

        case (state_q)
            RUN:     if (!advance) state_d = STALL;
            STALL:   if (advance)  state_d = RUN;
            default: state_d = RUN;
        endcase

        if (!advance) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            inc_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            inc_flush  = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            inc_lu     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (inc_stall) stall_cnt <= stall_cnt + CNT_W'(1);
            if (inc_flush) flush_cnt <= flush_cnt + CNT_W'(1);
            if (inc_lu)    lu_cnt    <= lu_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. It generates the enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It freezes the pipeline while instruction or data memory is outstanding, inserts a bubble on load-use hazards and squashes younger instructions on a taken branch or jump. It also keeps stall, flush and load-use performance counters.

Parameters:
CNT_W, 32, width of each performance counter.
REG_W, 5, register-index width.

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  in  1  IF stage has an outstanding fetch this cycle
imem_resp  in  1  I-side memory response; one-cycle pulse per request
dmem_req  in  1  MEM stage holds a load/store awaiting memory
dmem_resp  in  1  D-side memory response; one-cycle pulse per request
id_rs1  in  REG_W  rs1 index of the instruction in ID
id_rs2  in  REG_W  rs2 index of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_W  destination index of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch or jump
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID flush; register loads zeros when en and flush are both high
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX flush
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
stall_cnt  out  CNT_W  cycles spent frozen on memory
flush_cnt  out  CNT_W  redirect flushes taken
lu_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. Reset clears state to RUN, clears both sticky flags and zeroes all counters.
- Sticky flags imem_done and dmem_done:
  - A flag is set when its resp arrives while its req is high and the pipeline does not advance that cycle.
  - Both flags clear on any advancing cycle.
  - A resp with no matching req is ignored.
- Readiness terms:
  - i_ok = !imem_req | imem_resp | imem_done
  - d_ok = !dmem_req | dmem_resp | dmem_done
  - advance = i_ok & d_ok. This is combinational and has zero latency from resp to the enables.
- Load-use term: lu = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Output priority, evaluated every cycle (all outputs are combinational from inputs and state):
  - 1) !advance: every en = 0 and every flush = 0. The whole pipeline is frozen.
  - 2) advance & ex_redirect: every en = 1, ifid_flush = 1, idex_flush = 1. Redirect beats lu because the dependent instruction is squashed anyway.
  - 3) advance & lu: pc_en = 0, ifid_en = 0, idex_en = 1 with idex_flush = 1 (bubble), exmem_en = 1, memwb_en = 1, ifid_flush = 0.
  - 4) Otherwise every en = 1 and every flush = 0.
- FSM states:
  - RUN goes to STALL on a cycle with !advance.
  - STALL goes to RUN on the cycle advance = 1; the enables assert in that same cycle.
  - State is visible only through the counters.
- Counters:
  - stall_cnt increments on every !advance cycle.
  - flush_cnt increments on case 2.
  - lu_cnt increments on case 3.
  - All counters wrap modulo 2^CNT_W.
- Reset outputs: with rst high and no requests pending, the combinational outputs follow case 4. All counters read 0.
- Boundary conditions:
  - Simultaneous imem_resp and dmem_resp advance in that cycle.
  - Responses arriving in different cycles: the first is held sticky and the pipeline advances on the second.
  - ex_redirect held during a stall takes effect on the advancing cycle; no flush is issued while frozen.
  - Reset asserted mid-stall discards both sticky flags.

Decomposition:
- A shared package (pipeline_ctrl_pkg) holds the state enum (RUN, STALL) and the default CNT_W constant.
- A single sub-module, mem_ready_tracker, holds one sticky flag and its req/resp logic. It is instantiated twice (I-side, D-side) and outputs its ok term.

Test Plan:
- Reset pulse, no requests -> all en = 1, flushes = 0, all counters = 0.
- imem_req = 1 held for 3 cycles with imem_resp on cycle 3 -> all en = 0 on cycles 1-2, all en = 1 on cycle 3, stall_cnt = 2.
- imem_req and dmem_req both high; dmem_resp on cycle 1, imem_resp on cycle 4 -> frozen on cycles 1-3, advance on cycle 4, dmem_done cleared afterwards, stall_cnt = 3.
- ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> pc_en = 0, ifid_en = 0, idex_flush = 1, lu_cnt = 1. Repeat with ex_rd = 0 -> no bubble.
- ex_redirect = 1 together with a load-use match -> ifid_flush = 1, idex_flush = 1, pc_en = 1, flush_cnt = 1, lu_cnt unchanged.
- ex_redirect = 1 during a dmem stall, with dmem_resp 2 cycles later -> flushes = 0 while frozen, flushes = 1 on the resp cycle. Then assert rst mid-stall -> counters = 0 and sticky flags cleared.
